// File: rtl/issue_scoreboard.sv
// Register scoreboard and hazard controller for the dual-slot in-order issue stage.
// Tracks registers awaiting long write-back and qualifies slot-0/slot-1 issue each cycle.
module issue_scoreboard #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        s0_valid,
  input  logic [4:0]  s0_rd,
  input  logic [4:0]  s0_rj,
  input  logic [4:0]  s0_rk,
  input  logic        s0_wen,
  input  logic        s0_long,
  input  logic        s1_valid,
  input  logic [4:0]  s1_rd,
  input  logic [4:0]  s1_rj,
  input  logic [4:0]  s1_rk,
  input  logic        s1_wen,
  input  logic        s0_fire,
  input  logic        s1_fire,
  input  logic        lwb_valid,
  input  logic [4:0]  lwb_rd,
  output logic        s0_ok,
  output logic        s1_ok,
  output logic [31:0] busy_vec,
  output logic [2:0]  outstanding,
  output logic        full,
  output logic        sb_err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic        h0;
  logic        h1;
  logic        pair_dep;
  logic        set_req;
  logic        clr_req;
  logic        err_evt;
  logic [31:0] busy_nxt;
  logic [2:0]  cnt_nxt;

  // Register r0 is hardwired, so it never counts as a pending producer.
  function automatic logic busy_of(input logic [31:0] vec, input logic [4:0] idx);
    return (idx != 5'd0) && vec[idx];
  endfunction

  always_comb begin
    h0 = busy_of(busy_vec, s0_rj) || busy_of(busy_vec, s0_rk) ||
         (s0_wen && busy_of(busy_vec, s0_rd)) ||
         (s0_long && s0_wen && full);
    s0_ok = s0_valid && !h0;

    pair_dep = s0_wen && (s0_rd != 5'd0) &&
               ((s0_rd == s1_rj) || (s0_rd == s1_rk) || (s1_wen && (s0_rd == s1_rd)));
    h1 = busy_of(busy_vec, s1_rj) || busy_of(busy_vec, s1_rk) ||
         (s1_wen && busy_of(busy_vec, s1_rd)) || pair_dep;
    s1_ok = s1_valid && s0_ok && !h1;
  end

  assign set_req = s0_fire && s0_long && s0_wen && (s0_rd != 5'd0);
  assign clr_req = lwb_valid && (lwb_rd != 5'd0);

  always_comb begin
    busy_nxt = busy_vec;
    cnt_nxt  = outstanding;
    err_evt  = 1'b0;
    if (flush) begin
      // Long units are flushed alongside us; in-cycle fires and write-backs are dropped.
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      err_evt = (s0_fire && !s0_ok) || (s1_fire && !s1_ok) || (s1_fire && !s0_fire);
      if (set_req && clr_req && (s0_rd == lwb_rd)) begin
        busy_nxt[s0_rd] = 1'b1;
        err_evt         = 1'b1;
      end else begin
        if (clr_req) begin
          if (!busy_vec[lwb_rd] || (outstanding == 3'd0)) begin
            err_evt = 1'b1;
          end else begin
            busy_nxt[lwb_rd] = 1'b0;
            cnt_nxt          = cnt_nxt - 3'd1;
          end
        end
        if (set_req) begin
          busy_nxt[s0_rd] = 1'b1;
          cnt_nxt         = cnt_nxt + 3'd1;
        end
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec    <= '0;
      outstanding <= '0;
      full        <= 1'b0;
      sb_err      <= 1'b0;
    end else begin
      busy_vec    <= busy_nxt;
      outstanding <= cnt_nxt;
      full        <= (cnt_nxt == MAX_CNT);
      sb_err      <= sb_err || err_evt;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic compared against a behavioural scoreboard model.
module tb_issue_scoreboard;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        s0_valid, s0_wen, s0_long;
  logic [4:0]  s0_rd, s0_rj, s0_rk;
  logic        s1_valid, s1_wen;
  logic [4:0]  s1_rd, s1_rj, s1_rk;
  logic        s0_fire, s1_fire;
  logic        lwb_valid;
  logic [4:0]  lwb_rd;
  logic        s0_ok, s1_ok;
  logic [31:0] busy_vec;
  logic [2:0]  outstanding;
  logic        full;
  logic        sb_err;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit m_busy[32];
  int m_cnt;
  bit m_err;

  issue_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_rj(s0_rj), .s0_rk(s0_rk),
    .s0_wen(s0_wen), .s0_long(s0_long),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_rj(s1_rj), .s1_rk(s1_rk), .s1_wen(s1_wen),
    .s0_fire(s0_fire), .s1_fire(s1_fire),
    .lwb_valid(lwb_valid), .lwb_rd(lwb_rd),
    .s0_ok(s0_ok), .s1_ok(s1_ok), .busy_vec(busy_vec),
    .outstanding(outstanding), .full(full), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush = 0; s0_valid = 0; s0_rd = 0; s0_rj = 0; s0_rk = 0; s0_wen = 0; s0_long = 0;
    s1_valid = 0; s1_rd = 0; s1_rj = 0; s1_rk = 0; s1_wen = 0;
    s0_fire = 0; s1_fire = 0; lwb_valid = 0; lwb_rd = 0;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  function automatic bit m_bz(input logic [4:0] idx);
    return (idx != 0) && m_busy[idx];
  endfunction

  function automatic bit m_ok0();
    bit haz;
    haz = m_bz(s0_rj) || m_bz(s0_rk) || (s0_wen && m_bz(s0_rd)) ||
          (s0_long && s0_wen && (m_cnt == MAXO));
    return s0_valid && !haz;
  endfunction

  function automatic bit m_ok1();
    bit haz;
    haz = m_bz(s1_rj) || m_bz(s1_rk) || (s1_wen && m_bz(s1_rd));
    if (s0_wen && s0_rd != 0 &&
        (s0_rd == s1_rj || s0_rd == s1_rk || (s1_wen && s0_rd == s1_rd))) haz = 1;
    return s1_valid && m_ok0() && !haz;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Applies one clock edge of scoreboard rules to the model; call before the edge.
  task automatic model_step(input bit ok0, input bit ok1);
    bit set, clr;
    set = s0_fire && s0_long && s0_wen && s0_rd != 0;
    clr = lwb_valid && lwb_rd != 0;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_cnt = 0;
    end else begin
      if ((s0_fire && !ok0) || (s1_fire && !ok1) || (s1_fire && !s0_fire)) m_err = 1;
      if (set && clr && s0_rd == lwb_rd) begin
        m_busy[s0_rd] = 1;
        m_err = 1;
      end else begin
        if (clr) begin
          if (!m_busy[lwb_rd] || m_cnt == 0) m_err = 1;
          else begin m_busy[lwb_rd] = 0; m_cnt = m_cnt - 1; end
        end
        if (set) begin m_busy[s0_rd] = 1; m_cnt = (m_cnt + 1) % 8; end
      end
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 0;
    #1 rst = 1;
    #1;
    checks++; if (busy_vec !== 32'h0) $display("FAIL reset_busy got=%h exp=0", busy_vec); else passes++;
    checks++; if (outstanding !== 3'd0) $display("FAIL reset_outstanding got=%0d exp=0", outstanding); else passes++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passes++;
    checks++; if (sb_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", sb_err); else passes++;
    checks++; if (s0_ok !== 1'b0 || s1_ok !== 1'b0) $display("FAIL reset_ok got=%b%b exp=00", s0_ok, s1_ok); else passes++;
    tick();
    rst = 0;
  endtask

  task automatic test_long_raw;
    clear_inputs();
    s0_valid = 1; s0_rd = 5; s0_wen = 1; s0_long = 1;
    #1;
    checks++; if (s0_ok !== 1'b1) $display("FAIL raw_issue_ok got=%b exp=1", s0_ok); else passes++;
    s0_fire = 1;
    tick();
    clear_inputs();
    s0_valid = 1; s0_rj = 5;
    #1;
    checks++; if (s0_ok !== 1'b0) $display("FAIL raw_stall got=%b exp=0", s0_ok); else passes++;
    checks++; if (busy_vec !== 32'h20) $display("FAIL raw_busy got=%h exp=20", busy_vec); else passes++;
    checks++; if (outstanding !== 3'd1) $display("FAIL raw_cnt1 got=%0d exp=1", outstanding); else passes++;
    tick();
    checks++; if (s0_ok !== 1'b0 || busy_vec !== 32'h20) $display("FAIL raw_hold got ok=%b busy=%h exp ok=0 busy=20", s0_ok, busy_vec); else passes++;
    lwb_valid = 1; lwb_rd = 5;
    #1;
    checks++; if (s0_ok !== 1'b0) $display("FAIL raw_no_bypass got=%b exp=0", s0_ok); else passes++;
    tick();
    lwb_valid = 0;
    #1;
    checks++; if (s0_ok !== 1'b1) $display("FAIL raw_release got=%b exp=1", s0_ok); else passes++;
    checks++; if (outstanding !== 3'd0 || busy_vec !== 32'h0) $display("FAIL raw_cleared got cnt=%0d busy=%h exp cnt=0 busy=0", outstanding, busy_vec); else passes++;
    checks++; if (sb_err !== 1'b0) $display("FAIL raw_err got=%b exp=0", sb_err); else passes++;
  endtask

  task automatic test_intra_pair;
    clear_inputs();
    s0_valid = 1; s0_wen = 1; s0_rd = 3;
    s1_valid = 1; s1_rk = 3; s1_rd = 7; s1_wen = 1;
    #1;
    checks++; if (s0_ok !== 1'b1) $display("FAIL pair_s0 got=%b exp=1", s0_ok); else passes++;
    checks++; if (s1_ok !== 1'b0) $display("FAIL pair_s1_dep got=%b exp=0", s1_ok); else passes++;
    s0_rd = 0;
    #1;
    checks++; if (s1_ok !== 1'b1) $display("FAIL pair_s1_r0 got=%b exp=1", s1_ok); else passes++;
    s0_rd = 7; s1_rk = 2;
    #1;
    checks++; if (s1_ok !== 1'b0) $display("FAIL pair_waw got=%b exp=0", s1_ok); else passes++;
    clear_inputs();
  endtask

  task automatic test_capacity;
    clear_inputs();
    for (int r = 1; r <= 4; r++) begin
      s0_valid = 1; s0_wen = 1; s0_long = 1; s0_rd = 5'(r); s0_fire = 1;
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (full !== 1'b1 || outstanding !== 3'd4) $display("FAIL cap_full got full=%b cnt=%0d exp full=1 cnt=4", full, outstanding); else passes++;
    checks++; if (busy_vec !== 32'h1E) $display("FAIL cap_busy got=%h exp=1e", busy_vec); else passes++;
    s0_valid = 1; s0_wen = 1; s0_long = 1; s0_rd = 6;
    #1;
    checks++; if (s0_ok !== 1'b0) $display("FAIL cap_long_stall got=%b exp=0", s0_ok); else passes++;
    s0_long = 0;
    #1;
    checks++; if (s0_ok !== 1'b1) $display("FAIL cap_alu_ok got=%b exp=1", s0_ok); else passes++;
    s0_long = 1; s0_fire = 1; lwb_valid = 1; lwb_rd = 2;
    tick();
    clear_inputs();
    checks++; if (outstanding !== 3'd4) $display("FAIL cap_swap_cnt got=%0d exp=4", outstanding); else passes++;
    checks++; if (busy_vec !== 32'h5A) $display("FAIL cap_swap_busy got=%h exp=5a", busy_vec); else passes++;
    // That fire was issued while s0_ok was low, so it is a protocol error.
    checks++; if (sb_err !== 1'b1) $display("FAIL cap_swap_err got=%b exp=1", sb_err); else passes++;
  endtask

  task automatic test_async_reset;
    clear_inputs();
    s0_valid = 1;
    #2 rst = 1;
    #1;
    checks++; if (busy_vec !== 32'h0 || outstanding !== 3'd0) $display("FAIL areset_state got busy=%h cnt=%0d exp 0 0", busy_vec, outstanding); else passes++;
    checks++; if (full !== 1'b0 || sb_err !== 1'b0) $display("FAIL areset_flags got full=%b err=%b exp 0 0", full, sb_err); else passes++;
    checks++; if (s0_ok !== 1'b1 || s1_ok !== 1'b0) $display("FAIL areset_ok got=%b%b exp=10", s0_ok, s1_ok); else passes++;
    #1 rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_flush;
    clear_inputs();
    for (int r = 1; r <= 3; r++) begin
      s0_valid = 1; s0_wen = 1; s0_long = 1; s0_rd = 5'(r); s0_fire = 1;
      tick();
    end
    clear_inputs();
    checks++; if (outstanding !== 3'd3) $display("FAIL flush_pre got=%0d exp=3", outstanding); else passes++;
    flush = 1; lwb_valid = 1; lwb_rd = 1;
    tick();
    clear_inputs();
    checks++; if (busy_vec !== 32'h0 || outstanding !== 3'd0 || full !== 1'b0) $display("FAIL flush_state got busy=%h cnt=%0d full=%b exp 0", busy_vec, outstanding, full); else passes++;
    checks++; if (sb_err !== 1'b0) $display("FAIL flush_err got=%b exp=0", sb_err); else passes++;
  endtask

  task automatic test_protocol;
    clear_inputs();
    lwb_valid = 1; lwb_rd = 9;
    tick();
    clear_inputs();
    checks++; if (sb_err !== 1'b1) $display("FAIL proto_lwb got=%b exp=1", sb_err); else passes++;
    checks++; if (outstanding !== 3'd0 || busy_vec !== 32'h0) $display("FAIL proto_ignored got cnt=%0d busy=%h exp 0", outstanding, busy_vec); else passes++;
    flush = 1;
    tick();
    clear_inputs();
    checks++; if (sb_err !== 1'b1) $display("FAIL proto_sticky_flush got=%b exp=1", sb_err); else passes++;
    rst = 1;
    #1 rst = 0;
    #1;
    checks++; if (sb_err !== 1'b0) $display("FAIL proto_rst_clear got=%b exp=0", sb_err); else passes++;
    s1_valid = 1; s1_rd = 4; s1_wen = 1; s1_fire = 1;
    tick();
    clear_inputs();
    checks++; if (sb_err !== 1'b1) $display("FAIL proto_s1_alone got=%b exp=1", sb_err); else passes++;
    rst = 1;
    #1 rst = 0;
    tick();
  endtask

  task automatic test_random;
    bit e0, e1;
    logic [4:0] r;
    clear_inputs();
    rst = 1;
    #1 rst = 0;
    model_clear();
    tick();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        rst = 1;
        #1 rst = 0;
        model_clear();
      end
      clear_inputs();
      s0_valid = ($urandom_range(0, 3) != 0);
      s0_rd = 5'($urandom_range(0, 7)); s0_rj = 5'($urandom_range(0, 7)); s0_rk = 5'($urandom_range(0, 7));
      s0_wen = 1'($urandom_range(0, 1)); s0_long = ($urandom_range(0, 2) != 0);
      s1_valid = 1'($urandom_range(0, 1));
      s1_rd = 5'($urandom_range(0, 7)); s1_rj = 5'($urandom_range(0, 7)); s1_rk = 5'($urandom_range(0, 7));
      s1_wen = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 39) == 0);
      if (!flush && $urandom_range(0, 2) == 0) begin
        r = 5'($urandom_range(1, 7));
        for (int k = 0; k < 7 && !m_busy[r]; k++) r = (r % 5'd7) + 5'd1;
        if ($urandom_range(0, 15) == 0) r = 5'($urandom_range(0, 15));
        lwb_valid = 1; lwb_rd = r;
      end
      #1;
      e0 = m_ok0();
      e1 = m_ok1();
      checks++; if (s0_ok !== e0) $display("FAIL rnd_s0_ok cyc=%0d got=%b exp=%b", i, s0_ok, e0); else passes++;
      checks++; if (s1_ok !== e1) $display("FAIL rnd_s1_ok cyc=%0d got=%b exp=%b", i, s1_ok, e1); else passes++;
      if (!flush) begin
        s0_fire = e0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
        s1_fire = (e1 && s0_fire) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      end
      model_step(e0, e1);
      tick();
      checks++; if (busy_vec !== m_vec()) $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", i, busy_vec, m_vec()); else passes++;
      checks++; if (outstanding !== 3'(m_cnt) || full !== (m_cnt == MAXO)) $display("FAIL rnd_cnt cyc=%0d got=%0d/%b exp=%0d/%b", i, outstanding, full, m_cnt, (m_cnt == MAXO)); else passes++;
      checks++; if (sb_err !== m_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, sb_err, m_err); else passes++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_long_raw();
    test_intra_pair();
    test_capacity();
    test_async_reset();
    test_flush();
    test_protocol();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
